equiv_monitor: RTL and testbench
================================

# equiv_monitor

Parametrised lockstep equivalence monitor for the fuzz equivalence harnesses. It compares CHANNELS output words from two implementations of the same design, such as pre- and post-synthesis netlists. It aligns their differing pipeline latencies, then records mismatches. It reports a sticky fail flag, a saturating mismatch count and a snapshot of the first divergence, so a harness can check several outputs and skewed netlists instead of only comparing one word combinationally.

## Interface
- WIDTH, 91: bits per channel word.
- CHANNELS, 2: number of compared output words.
- DELAY_A, 0: extra register stages on the A path, 0..15.
- DELAY_B, 0: extra register stages on the B path, 0..15.
- WARMUP, 4: compare-eligible cycles ignored after reset or clear, 0..255.
- CNT_W, 16: width of the mismatch counter and the cycle stamp.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous; returns the block to the post-reset state.
- in_valid  in  1  current a_data/b_data is a sample to compare.
- chan_mask  in  CHANNELS  1 = channel compared; sampled with the data and delayed along the A path.
- a_data  in  CHANNELS*WIDTH  implementation A outputs; channel i is bits [i*WIDTH +: WIDTH].
- b_data  in  CHANNELS*WIDTH  implementation B outputs.
- mismatch_pulse  out  1  one-cycle strobe per mismatching aligned sample.
- fail  out  1  sticky; set on the first counted mismatch.
- mismatch_count  out  CNT_W  saturating count of mismatching samples.
- first_chan  out  clog2(CHANNELS) or 1  lowest-index mismatching channel of the first failure.
- first_a, first_b  out  WIDTH  A and B words of first_chan at the first failure.
- first_cycle  out  CNT_W  cycle stamp of the first failure.
- state  out  2  0 WARMUP, 1 CHECK, 2 FAILED.

## Operation
- The A path delays {in_valid, chan_mask, a_data} by DELAY_A stages. The B path delays {in_valid, b_data} by DELAY_B stages. Each path is a plain shift register; a delay of 0 means a wire.
- A sample is aligned when va && vb, where va and vb are the delayed valids. If only one side is valid, nothing is compared and nothing is flagged.
- Channel i mismatches when mask_d[i] and a_d[i] != b_d[i]. A sample mismatches when any channel mismatches.
- state machine:
  - WARMUP: each aligned sample decrements wcnt, which starts at WARMUP; mismatches are ignored. Go to CHECK when wcnt reaches 0. If WARMUP = 0, go directly to CHECK.
  - CHECK: a mismatching aligned sample pulses mismatch_pulse, increments the count, sets fail, captures first_*, and moves to FAILED.
  - FAILED: mismatch_pulse and the count keep updating; first_* is frozen. Only rst or clear leaves this state.
- mismatch_count saturates at 2^CNT_W-1 and does not wrap.
- cyc is a free-running cycle counter that saturates at all-ones and is cleared by rst and clear. first_cycle captures cyc at the compare cycle.
- clear has priority over a compare in the same cycle: the sample is discarded. clear also flushes both delay lines, setting all valids to 0.
- Reset and clear values:
  - state = WARMUP.
  - fail, mismatch_pulse, mismatch_count, first_chan, first_a, first_b, first_cycle, cyc = 0.
  - all delay-line valids = 0.
  - When rst is asserted mid-run, all outputs go to these values immediately (asynchronously).

## Timing
- Sample driven at cycle t is aligned at cycle t+max(DELAY_A, DELAY_B), provided the two sides line up. The harness delays are chosen so this holds.
- Every output is registered; the compare result is visible one cycle after alignment.
- Total latency from in_valid at cycle t to mismatch_pulse/fail: t+max(DELAY_A, DELAY_B)+1.
- In back-to-back mismatching samples, mismatch_pulse stays high every cycle.
- first_* is stable from the cycle fail rises until rst or clear.

## Configuration
- EQUIV_MONITOR_ASSERT_EN defined: an immediate assert(!(aligned && any_mismatch)) is compiled into the clocked compare, active in CHECK and FAILED only. This gives simulation or formal tools a hard failure at the first divergence.
- Not defined: no assertion; the block is pure synthesizable monitoring logic and reports only through its outputs.

## Structure
- Package equiv_pkg holds:
  - the state enum (WARMUP, CHECK, FAILED);
  - the localparam helper for the first_chan width;
  - a max-of-two delay function.
- Sub-module equiv_delay_line (parameters DEPTH and W; valid plus data shift register with synchronous flush) is instantiated once per path.

## Test plan
- WIDTH=8, CHANNELS=2, delays 0, WARMUP=0; identical data 0x00..0x1F for 32 cycles. Required: fail=0, count=0, state=CHECK.
- Same setup, cycle 5: a ch1=0x3C, b ch1=0x3D, ch0 equal. Required: pulse at cycle 6, fail=1, first_chan=1, first_a=0x3C, first_b=0x3D, first_cycle=5, state=FAILED.
- DELAY_A=2, DELAY_B=0; B stream is the A stream delayed by 2 cycles. Required: no mismatch. A mismatch injected at A cycle 10 gives a pulse at cycle 13.
- WARMUP=4; mismatches on aligned samples 0..3 and matches after. Required: count=0, CHECK entered after the 4th aligned sample.
- CNT_W=3; 10 consecutive mismatching samples. Required: count saturates at 7, first_* holds the first sample, pulse high for 10 cycles.
- rst mid-FAILED, then clear asserted in the same cycle as a mismatch. Required: all outputs 0 and state=WARMUP; the discarded sample is not counted; chan_mask=0 on the mismatching channel yields no flag.

Source files
------------

// File: rtl/equiv_pkg.sv
// Shared types and helpers for the lockstep equivalence monitor.
package equiv_pkg;

  typedef enum logic [1:0] {
    ST_WARMUP = 2'd0,
    ST_CHECK  = 2'd1,
    ST_FAILED = 2'd2
  } state_t;

  // Width of a channel index; a single channel still needs one bit.
  function automatic int chan_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/equiv_delay_line.sv
// Valid-plus-data shift register of DEPTH stages with synchronous flush.
// DEPTH = 0 degenerates to a wire.
module equiv_delay_line #(
  parameter int DEPTH = 0,
  parameter int W     = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  if (DEPTH == 0) begin : g_wire
    logic unused_ctrl;
    assign unused_ctrl = ^{clk, rst, flush};
    assign out_valid   = in_valid;
    assign out_data    = in_data;
  end else begin : g_sr
    logic [DEPTH-1:0] valid_q;
    logic [W-1:0]     data_q [DEPTH];

    // Flush drops only the valids; stale data behind a 0 valid is harmless.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_q <= '0;
        for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
      end else if (flush) begin
        valid_q <= '0;
      end else begin
        valid_q[0] <= in_valid;
        data_q[0]  <= in_data;
        for (int i = 1; i < DEPTH; i++) begin
          valid_q[i] <= valid_q[i-1];
          data_q[i]  <= data_q[i-1];
        end
      end
    end

    assign out_valid = valid_q[DEPTH-1];
    assign out_data  = data_q[DEPTH-1];
  end

endmodule

// File: rtl/equiv_monitor.sv
// Lockstep equivalence monitor: aligns two skewed output streams and records mismatches.
// Optional macro EQUIV_MONITOR_ASSERT_EN compiles in a hard assertion on divergence.
module equiv_monitor
  import equiv_pkg::*;
#(
  parameter int WIDTH    = 91,
  parameter int CHANNELS = 2,
  parameter int DELAY_A  = 0,
  parameter int DELAY_B  = 0,
  parameter int WARMUP   = 4,
  parameter int CNT_W    = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              clear,
  input  logic                              in_valid,
  input  logic [CHANNELS-1:0]               chan_mask,
  input  logic [CHANNELS*WIDTH-1:0]         a_data,
  input  logic [CHANNELS*WIDTH-1:0]         b_data,
  output logic                              mismatch_pulse,
  output logic                              fail,
  output logic [CNT_W-1:0]                  mismatch_count,
  output logic [chan_idx_w(CHANNELS)-1:0]   first_chan,
  output logic [WIDTH-1:0]                  first_a,
  output logic [WIDTH-1:0]                  first_b,
  output logic [CNT_W-1:0]                  first_cycle,
  output logic [1:0]                        state
);

  localparam int CHW = chan_idx_w(CHANNELS);
  localparam int AW  = CHANNELS + CHANNELS * WIDTH;

  logic                      va, vb, aligned, any_mm, eligible, hit;
  logic [AW-1:0]             a_pack;
  logic [CHANNELS-1:0]       mask_d;
  logic [CHANNELS*WIDTH-1:0] a_d, b_d;
  logic [CHW-1:0]            mm_chan;
  logic [WIDTH-1:0]          mm_a, mm_b;

  equiv_delay_line #(.DEPTH(DELAY_A), .W(AW)) u_dly_a (
    .clk(clk), .rst(rst), .flush(clear), .in_valid(in_valid),
    .in_data({chan_mask, a_data}), .out_valid(va), .out_data(a_pack)
  );

  equiv_delay_line #(.DEPTH(DELAY_B), .W(CHANNELS*WIDTH)) u_dly_b (
    .clk(clk), .rst(rst), .flush(clear), .in_valid(in_valid),
    .in_data(b_data), .out_valid(vb), .out_data(b_d)
  );

  assign mask_d  = a_pack[AW-1 -: CHANNELS];
  assign a_d     = a_pack[CHANNELS*WIDTH-1:0];
  assign aligned = va && vb;

  // Scan high to low so the lowest mismatching channel wins.
  always_comb begin
    any_mm  = 1'b0;
    mm_chan = '0;
    mm_a    = '0;
    mm_b    = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (mask_d[i] && (a_d[i*WIDTH +: WIDTH] != b_d[i*WIDTH +: WIDTH])) begin
        any_mm  = 1'b1;
        mm_chan = CHW'(i);
        mm_a    = a_d[i*WIDTH +: WIDTH];
        mm_b    = b_d[i*WIDTH +: WIDTH];
      end
    end
  end

  state_t           state_q, state_d;
  logic [7:0]       wcnt_q, wcnt_d;
  logic             fail_q, fail_d, pulse_q, pulse_d;
  logic [CNT_W-1:0] count_q, count_d, cyc_q, cyc_d, fcyc_q, fcyc_d;
  logic [CHW-1:0]   fchan_q, fchan_d;
  logic [WIDTH-1:0] fa_q, fa_d, fb_q, fb_d;

  // A WARMUP of 0 leaves wcnt at 0, so even the very first sample is compared.
  assign eligible = (state_q != ST_WARMUP) || (wcnt_q == '0);
  assign hit      = aligned && any_mm && eligible;

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    fail_d  = fail_q;
    pulse_d = 1'b0;
    count_d = count_q;
    fchan_d = fchan_q;
    fa_d    = fa_q;
    fb_d    = fb_q;
    fcyc_d  = fcyc_q;
    cyc_d   = (cyc_q == '1) ? cyc_q : cyc_q + 1'b1;
    if (clear) begin
      state_d = ST_WARMUP;
      wcnt_d  = 8'(WARMUP);
      fail_d  = 1'b0;
      count_d = '0;
      fchan_d = '0;
      fa_d    = '0;
      fb_d    = '0;
      fcyc_d  = '0;
      cyc_d   = '0;
    end else begin
      if (state_q == ST_WARMUP) begin
        if (wcnt_q == '0) begin
          state_d = ST_CHECK;
        end else if (aligned) begin
          wcnt_d = wcnt_q - 1'b1;
          if (wcnt_q == 8'd1) state_d = ST_CHECK;
        end
      end
      if (hit) begin
        pulse_d = 1'b1;
        fail_d  = 1'b1;
        if (count_q != '1) count_d = count_q + 1'b1;
        if (!fail_q) begin
          state_d = ST_FAILED;
          fchan_d = mm_chan;
          fa_d    = mm_a;
          fb_d    = mm_b;
          fcyc_d  = cyc_q;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_WARMUP;
      wcnt_q  <= 8'(WARMUP);
      fail_q  <= 1'b0;
      pulse_q <= 1'b0;
      count_q <= '0;
      fchan_q <= '0;
      fa_q    <= '0;
      fb_q    <= '0;
      fcyc_q  <= '0;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      fail_q  <= fail_d;
      pulse_q <= pulse_d;
      count_q <= count_d;
      fchan_q <= fchan_d;
      fa_q    <= fa_d;
      fb_q    <= fb_d;
      fcyc_q  <= fcyc_d;
      cyc_q   <= cyc_d;
`ifdef EQUIV_MONITOR_ASSERT_EN
      if (!clear && state_q != ST_WARMUP) assert (!(aligned && any_mm));
`endif
    end
  end

  assign mismatch_pulse = pulse_q;
  assign fail           = fail_q;
  assign mismatch_count = count_q;
  assign first_chan     = fchan_q;
  assign first_a        = fa_q;
  assign first_b        = fb_q;
  assign first_cycle    = fcyc_q;
  assign state          = state_q;

endmodule

// File: tb/tb_equiv_monitor.sv
// Bench for equiv_monitor: two instances (unskewed/short counter, skewed/warmup) against a cycle model.
module tb_equiv_monitor;
  import equiv_pkg::*;

  localparam int W    = 8;
  localparam int CH   = 2;
  localparam int LAT1 = max2(2, 0);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        clr0 = 1'b0, iv0 = 1'b0, clr1 = 1'b0, iv1 = 1'b0;
  logic [1:0]  msk0 = '0, msk1 = '0;
  logic [15:0] ad0 = '0, bd0 = '0, ad1 = '0, bd1 = '0;
  logic        p0, f0, fc0, p1, f1, fc1;
  logic [2:0]  c0, fy0;
  logic [15:0] c1, fy1;
  logic [7:0]  fa0, fb0, fa1, fb1;
  logic [1:0]  s0, s1;

  equiv_monitor #(.WIDTH(W), .CHANNELS(CH), .DELAY_A(0), .DELAY_B(0), .WARMUP(0), .CNT_W(3)) u_dut0 (
    .clk(clk), .rst(rst), .clear(clr0), .in_valid(iv0), .chan_mask(msk0), .a_data(ad0), .b_data(bd0),
    .mismatch_pulse(p0), .fail(f0), .mismatch_count(c0), .first_chan(fc0), .first_a(fa0),
    .first_b(fb0), .first_cycle(fy0), .state(s0)
  );

  equiv_monitor #(.WIDTH(W), .CHANNELS(CH), .DELAY_A(2), .DELAY_B(0), .WARMUP(4), .CNT_W(16)) u_dut1 (
    .clk(clk), .rst(rst), .clear(clr1), .in_valid(iv1), .chan_mask(msk1), .a_data(ad1), .b_data(bd1),
    .mismatch_pulse(p1), .fail(f1), .mismatch_count(c1), .first_chan(fc1), .first_a(fa1),
    .first_b(fb1), .first_cycle(fy1), .state(s1)
  );

  // ---------------- checking ----------------
  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int da[2]   = '{0, 2};
  int db[2]   = '{0, 0};
  int wu[2]   = '{0, 4};
  int cmax[2] = '{7, 65535};

  int m_w[2], m_cnt[2], m_fch[2], m_fa[2], m_fb[2], m_fcyc[2], m_cyc[2], m_st[2];
  bit m_fail[2], m_p[2];
  bit          hv[2][16];
  logic [1:0]  hm[2][16];
  logic [15:0] ha[2][16], hb[2][16];

  task automatic model_reset(input int k);
    m_w[k] = wu[k]; m_cnt[k] = 0; m_fch[k] = 0; m_fa[k] = 0; m_fb[k] = 0;
    m_fcyc[k] = 0; m_cyc[k] = 0; m_st[k] = 0; m_fail[k] = 0; m_p[k] = 0;
    for (int i = 0; i < 16; i++) hv[k][i] = 1'b0;
  endtask

  // History index n holds what was driven n edges ago; the A side sees index da, B sees db.
  task automatic model_step(input int k);
    bit va, vb, mm;
    int fch;
    logic [7:0] xa, xb, ea, eb;
    logic [1:0] mk;
    logic [15:0] aw, bw;
    for (int i = 15; i > 0; i--) begin
      hv[k][i] = hv[k][i-1]; hm[k][i] = hm[k][i-1]; ha[k][i] = ha[k][i-1]; hb[k][i] = hb[k][i-1];
    end
    hv[k][0] = (k == 0) ? iv0 : iv1;
    hm[k][0] = (k == 0) ? msk0 : msk1;
    ha[k][0] = (k == 0) ? ad0 : ad1;
    hb[k][0] = (k == 0) ? bd0 : bd1;
    if (rst || ((k == 0) ? clr0 : clr1)) begin
      model_reset(k);
    end else begin
      va = hv[k][da[k]]; vb = hv[k][db[k]];
      mk = hm[k][da[k]]; aw = ha[k][da[k]]; bw = hb[k][db[k]];
      mm = 0; fch = 0; ea = '0; eb = '0;
      for (int c = CH - 1; c >= 0; c--) begin
        xa = aw[c*8 +: 8];
        xb = bw[c*8 +: 8];
        if (mk[c] && xa != xb) begin mm = 1; fch = c; ea = xa; eb = xb; end
      end
      m_p[k] = 0;
      if (va && vb) begin
        if (m_w[k] > 0) m_w[k]--;
        else if (mm) begin
          m_p[k] = 1;
          if (m_cnt[k] < cmax[k]) m_cnt[k]++;
          if (!m_fail[k]) begin
            m_fail[k] = 1; m_fch[k] = fch; m_fa[k] = ea; m_fb[k] = eb; m_fcyc[k] = m_cyc[k];
          end
        end
      end
      m_st[k] = m_fail[k] ? 2 : ((m_w[k] == 0) ? 1 : 0);
      if (m_cyc[k] < cmax[k]) m_cyc[k]++;
    end
  endtask

  function automatic logic [63:0] pack_exp(input int k);
    return {11'b0, m_p[k], m_fail[k], 16'(m_cnt[k]), 1'(m_fch[k]), 8'(m_fa[k]), 8'(m_fb[k]),
            16'(m_fcyc[k]), 2'(m_st[k])};
  endfunction

  function automatic logic [63:0] act(input int k);
    if (k == 0) return {11'b0, p0, f0, 13'b0, c0, fc0, fa0, fb0, 13'b0, fy0, s0};
    return {11'b0, p1, f1, c1, fc1, fa1, fb1, fy1, s1};
  endfunction

  // ---------------- scoreboard ----------------
  logic [63:0] exp_q0[$];
  logic [63:0] exp_q1[$];
  int ph;
  int pulses[2];
  int first_vis[2];

  task automatic start_phase();
    ph = 0;
    for (int k = 0; k < 2; k++) begin pulses[k] = 0; first_vis[k] = -1; end
  endtask

  task automatic score(input int k);
    logic [63:0] e, a;
    e = '1;
    if (k == 0 && exp_q0.size() > 0) e = exp_q0.pop_front();
    if (k == 1 && exp_q1.size() > 0) e = exp_q1.pop_front();
    a = act(k);
    check_eq((k == 0) ? "dut0_out" : "dut1_out", a, e);
    if (a[52]) begin
      pulses[k]++;
      if (first_vis[k] < 0) first_vis[k] = ph + 1;
    end
  endtask

  // ---------------- driver ----------------
  task automatic cycle();
    model_step(0);
    model_step(1);
    exp_q0.push_back(pack_exp(0));
    exp_q1.push_back(pack_exp(1));
    @(posedge clk);
    @(negedge clk);
    score(0);
    score(1);
    ph++;
  endtask

  logic [15:0] base[64];
  logic [15:0] rnd;
  logic [7:0]  sat_a, sat_b;

  initial begin
    model_reset(0);
    model_reset(1);
    for (int i = 0; i < 64; i++) base[i] = 16'($urandom_range(0, 65535));

    rst = 1'b1;
    cycle();
    cycle();
    check_eq("reset_dut0", act(0), 64'd0);
    check_eq("reset_dut1", act(1), 64'd0);
    rst = 1'b0;

    // dut0: identical ramp; dut1: B is A delayed by 2, warmup mismatches then one late divergence
    start_phase();
    for (int i = 0; i < 32; i++) begin
      iv0 = 1'b1; msk0 = 2'b11;
      ad0 = {8'(i), 8'(i)};
      bd0 = ad0;
      iv1 = 1'b1; msk1 = 2'b11;
      ad1 = base[i];
      if (i == 10) ad1 = base[i] ^ 16'h0100;
      bd1 = (i >= 2) ? base[i-2] : 16'($urandom_range(0, 65535));
      if (i >= 2 && i <= 5) bd1 = bd1 ^ 16'h0001;
      cycle();
      if (i == 5) begin
        check_eq("warmup_state", s1, 64'd1);
        check_eq("warmup_count", c1, 64'd0);
      end
    end
    iv0 = 1'b0; iv1 = 1'b0;
    check_eq("ramp_fail", f0, 64'd0);
    check_eq("ramp_count", c0, 64'd0);
    check_eq("ramp_state", s0, 64'd1);
    check_eq("skew_pulse_cycle", first_vis[1], 64'(10 + LAT1 + 1));
    check_eq("skew_count", c1, 64'd1);
    check_eq("skew_chan", fc1, 64'd1);
    check_eq("skew_first_a", fa1, base[10][15:8] ^ 8'h01);
    check_eq("skew_first_b", fb1, base[10][15:8]);
    check_eq("skew_first_cycle", fy1, 64'd12);
    check_eq("skew_state", s1, 64'd2);

    // dut0: single divergence on channel 1 at cycle 5
    clr0 = 1'b1;
    cycle();
    clr0 = 1'b0;
    start_phase();
    for (int i = 0; i < 12; i++) begin
      rnd = 16'($urandom_range(0, 65535));
      iv0 = 1'b1; msk0 = 2'b11;
      ad0 = rnd; bd0 = rnd;
      if (i == 5) begin ad0 = {8'h3C, rnd[7:0]}; bd0 = {8'h3D, rnd[7:0]}; end
      cycle();
    end
    iv0 = 1'b0;
    check_eq("single_pulse_cycle", first_vis[0], 64'd6);
    check_eq("single_fail", f0, 64'd1);
    check_eq("single_chan", fc0, 64'd1);
    check_eq("single_first_a", fa0, 64'h3C);
    check_eq("single_first_b", fb0, 64'h3D);
    check_eq("single_first_cycle", fy0, 64'd5);
    check_eq("single_state", s0, 64'd2);

    // dut0: 10 back-to-back mismatches saturate the 3-bit counter
    clr0 = 1'b1;
    cycle();
    clr0 = 1'b0;
    start_phase();
    for (int i = 0; i < 13; i++) begin
      rnd = 16'($urandom_range(0, 65535));
      iv0 = 1'b1; msk0 = 2'b11;
      ad0 = rnd;
      bd0 = (i < 10) ? {rnd[15:8], ~rnd[7:0]} : rnd;
      if (i == 0) begin sat_a = rnd[7:0]; sat_b = ~rnd[7:0]; end
      cycle();
    end
    iv0 = 1'b0;
    check_eq("sat_pulses", pulses[0], 64'd10);
    check_eq("sat_count", c0, 64'd7);
    check_eq("sat_chan", fc0, 64'd0);
    check_eq("sat_first_a", fa0, sat_a);
    check_eq("sat_first_b", fb0, sat_b);
    check_eq("sat_first_cycle", fy0, 64'd0);

    // asynchronous reset while both instances are FAILED
    check_eq("pre_rst_state1", s1, 64'd2);
    rst = 1'b1;
    #1;
    check_eq("rst_async_dut0", act(0), 64'd0);
    check_eq("rst_async_dut1", act(1), 64'd0);
    cycle();
    rst = 1'b0;

    // clear wins over a mismatching sample; masked channel never flags
    clr0 = 1'b1; iv0 = 1'b1; msk0 = 2'b11; ad0 = 16'h1234; bd0 = 16'h1235;
    cycle();
    clr0 = 1'b0;
    check_eq("clear_pulse", p0, 64'd0);
    check_eq("clear_count", c0, 64'd0);
    check_eq("clear_state", s0, 64'd0);
    msk0 = 2'b10;
    for (int i = 0; i < 3; i++) cycle();
    check_eq("masked_fail", f0, 64'd0);
    check_eq("masked_count", c0, 64'd0);
    check_eq("masked_state", s0, 64'd1);
    msk0 = 2'b11;
    cycle();
    iv0 = 1'b0;
    cycle();
    check_eq("unmasked_fail", f0, 64'd1);
    check_eq("unmasked_chan", fc0, 64'd0);
    check_eq("unmasked_first_a", fa0, 64'h34);
    check_eq("unmasked_first_b", fb0, 64'h35);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
